// File: rtl/cluster_level_shifter_in_iso.sv
// Input-side isolation cell for the cluster: synchronizes data and power-good from an external
// domain, clamps the data while isolated and releases only after power-good has settled.
module cluster_level_shifter_in_iso #(
   parameter int unsigned       WIDTH         = 1,
   parameter int unsigned       SYNC_STAGES   = 2,
   parameter int unsigned       SETTLE_CYCLES = 16,
   parameter logic [WIDTH-1:0]  CLAMP_VALUE   = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             pwr_ok_i,
   input  logic             iso_req_i,
   input  logic [WIDTH-1:0] in_i,
   output logic [WIDTH-1:0] out_o,
   output logic             iso_o,
   output logic             pwr_fail_o
);

   localparam int unsigned      CNT_W    = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

   localparam logic [1:0] ST_ISOLATED = 2'd0;
   localparam logic [1:0] ST_SETTLE   = 2'd1;
   localparam logic [1:0] ST_ACTIVE   = 2'd2;

   if (SYNC_STAGES < 2) begin : g_bad_sync_stages
      $error("cluster_level_shifter_in_iso: SYNC_STAGES must be >= 2");
   end
   if (SETTLE_CYCLES < 1) begin : g_bad_settle_cycles
      $error("cluster_level_shifter_in_iso: SETTLE_CYCLES must be >= 1");
   end

   // ------------------------------------------------------------------
   // Synchronizers
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0]            pwr_sync_q;
   logic [SYNC_STAGES-1:0][WIDTH-1:0] in_sync_q;
   logic                              pwr_ok_s;
   logic [WIDTH-1:0]                  in_s;

   // NOTE: every flop uses non-blocking assignment so each synchronizer stage samples the
   // previous stage's old value; blocking here would collapse the chain into one flop.
   // The sync flops are reset too, so a stale power-good can never open the clamp after reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pwr_sync_q <= '0;
         in_sync_q  <= '0;
      end else begin
         pwr_sync_q <= {pwr_sync_q[SYNC_STAGES-2:0], pwr_ok_i};
         in_sync_q  <= {in_sync_q[SYNC_STAGES-2:0], in_i};
      end
   end

   assign pwr_ok_s = pwr_sync_q[SYNC_STAGES-1];
   assign in_s     = in_sync_q[SYNC_STAGES-1];

   // ------------------------------------------------------------------
   // Isolation FSM
   // ------------------------------------------------------------------
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             leave;

   assign leave = iso_req_i | ~pwr_ok_s;

   // NOTE: defaults first so every path assigns state_d/cnt_d and no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_ISOLATED: begin
            if (!leave) begin
               state_d = ST_SETTLE;
               cnt_d   = '0;
            end
         end
         ST_SETTLE: begin
            // A leave request wins over a completed settle count.
            if (leave) begin
               state_d = ST_ISOLATED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_ACTIVE;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         ST_ACTIVE: begin
            if (leave) begin
               state_d = ST_ISOLATED;
            end
         end
         default: begin
            state_d = ST_ISOLATED;
            cnt_d   = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Registered outputs, derived from the next state
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] out_q, out_d;
   logic             iso_q, iso_d;
   logic             pwr_fail_q, pwr_fail_d;

   always_comb begin
      iso_d      = (state_d != ST_ACTIVE);
      out_d      = (state_d == ST_ACTIVE) ? in_s : CLAMP_VALUE;
      pwr_fail_d = (state_q == ST_ACTIVE) & ~pwr_ok_s & ~iso_req_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_ISOLATED;
         cnt_q      <= '0;
         out_q      <= CLAMP_VALUE;
         iso_q      <= 1'b1;
         pwr_fail_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         out_q      <= out_d;
         iso_q      <= iso_d;
         pwr_fail_q <= pwr_fail_d;
      end
   end

   assign out_o      = out_q;
   assign iso_o      = iso_q;
   assign pwr_fail_o = pwr_fail_q;

endmodule
